// File: rtl/vip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vip_pkg
// Description : Shared VIP Avalon-ST definitions: packet type codes, encoder
//               state encoding and the control-packet nibble packing helper
//               used by both the encoder and the control packet decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package vip_pkg;

  // Packet type nibbles carried in symbol 0 of the header beat
  localparam logic [3:0] VIP_TYPE_CTRL  = 4'hF;
  localparam logic [3:0] VIP_TYPE_VIDEO = 4'h0;

  // Control packet layout is defined for three 8-bit symbols per beat
  localparam int VIP_SYMBOL_BITS  = 8;
  localparam int VIP_CTRL_SYMBOLS = 3;
  localparam int VIP_CTRL_BEAT_W  = VIP_SYMBOL_BITS * VIP_CTRL_SYMBOLS;

  // Encoder state encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CTRL_HDR = 3'd1;
  localparam logic [2:0] ST_CTRL_D0  = 3'd2;
  localparam logic [2:0] ST_CTRL_D1  = 3'd3;
  localparam logic [2:0] ST_CTRL_D2  = 3'd4;
  localparam logic [2:0] ST_VID_HDR  = 3'd5;
  localparam logic [2:0] ST_VID_DATA = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_CTRL_HDR = ST_CTRL_HDR,
    S_CTRL_D0  = ST_CTRL_D0,
    S_CTRL_D1  = ST_CTRL_D1,
    S_CTRL_D2  = ST_CTRL_D2,
    S_VID_HDR  = ST_VID_HDR,
    S_VID_DATA = ST_VID_DATA
  } vip_enc_state_t;

  // Places one nibble in bits [3:0] of each symbol; n0 lands in symbol 0
  // (data[7:0]). The upper nibble of every symbol is zero.
  function automatic logic [VIP_CTRL_BEAT_W-1:0] vip_pack_nibbles(
    input logic [3:0] n0,
    input logic [3:0] n1,
    input logic [3:0] n2
  );
    return {4'h0, n2, 4'h0, n1, 4'h0, n0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/vip_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : vip_out_reg
// Description : Single-entry Avalon-ST output register (readyLatency 0).
//               Accepts a new beat whenever the slot is empty or the current
//               beat is being taken this cycle; holds all fields otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module vip_out_reg #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_sop,
  input  logic              load_eop,
  output logic              load_ok,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_valid,
  output logic              dout_startofpacket,
  output logic              dout_endofpacket
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_sop;
  logic              r_eop;

  // Slot is free when empty or when the sink takes the current beat now
  assign load_ok = ~r_valid | dout_ready;

  // Load a new beat, or drop valid once the held beat has been accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
    end else if (load && load_ok) begin
      r_data  <= load_data;
      r_valid <= 1'b1;
      r_sop   <= load_sop;
      r_eop   <= load_eop;
    end else if (dout_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign dout_data          = r_data;
  assign dout_valid         = r_valid;
  assign dout_startofpacket = r_sop;
  assign dout_endofpacket   = r_eop;

endmodule
`default_nettype wire

// File: rtl/vip_packet_encoder.sv
`default_nettype none
// ============================================================================
// Module      : vip_packet_encoder
// Description : Converts the algorithm core's flat pixel interface into a
//               VIP Avalon-ST stream: a control packet (type 0xF) carrying
//               width/height/interlace, followed by a video packet (type 0x0).
//               Flags a length error when the frame end disagrees with the
//               latched width*height.
// Revision    : 1.0 - initial release
// ============================================================================
module vip_packet_encoder
  import vip_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      write,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_in,
  input  logic                                      end_of_video,
  input  logic [15:0]                               width_in,
  input  logic [15:0]                               height_in,
  input  logic [3:0]                                interlaced_in,
  input  logic                                      vip_ctrl_send,
  output logic                                      stall_out,
  output logic                                      vip_ctrl_busy,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
  output logic                                      dout_valid,
  output logic                                      dout_startofpacket,
  output logic                                      dout_endofpacket,
  input  logic                                      dout_ready,
  output logic                                      length_error
);

  localparam int DATA_W = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

  vip_enc_state_t r_state;
  logic [15:0]    r_width;
  logic [15:0]    r_height;
  logic [3:0]     r_interlaced;
  logic [31:0]    r_frame_size;
  logic [31:0]    r_pixel_cnt;
  logic           r_length_error;

  logic              w_load_ok;
  logic              w_load;
  logic [DATA_W-1:0] w_beat_data;
  logic              w_beat_sop;
  logic              w_beat_eop;
  logic              w_in_video;
  logic              w_pix_load;
  logic              w_cnt_hit;
  logic              w_pix_eop;

  assign w_in_video = (r_state == S_VID_DATA);
  // A zero-area frame makes frame_size-1 wrap to all ones, so only
  // end_of_video can close it.
  assign w_cnt_hit  = (r_pixel_cnt == (r_frame_size - 32'd1));
  assign w_pix_load = w_in_video & write & w_load_ok;
  assign w_pix_eop  = end_of_video | w_cnt_hit;

  assign stall_out     = ~(w_in_video & w_load_ok);
  assign vip_ctrl_busy = (r_state != S_IDLE);
  assign length_error  = r_length_error;

  // Select the beat offered to the output register in each state
  always_comb begin
    w_load      = 1'b0;
    w_beat_data = '0;
    w_beat_sop  = 1'b0;
    w_beat_eop  = 1'b0;
    case (r_state)
      S_CTRL_HDR: begin
        w_load      = 1'b1;
        w_beat_data = DATA_W'(vip_pack_nibbles(VIP_TYPE_CTRL, 4'h0, 4'h0));
        w_beat_sop  = 1'b1;
      end
      S_CTRL_D0: begin
        w_load      = 1'b1;
        w_beat_data = DATA_W'(vip_pack_nibbles(r_width[15:12], r_width[11:8],
                                               r_width[7:4]));
      end
      S_CTRL_D1: begin
        w_load      = 1'b1;
        w_beat_data = DATA_W'(vip_pack_nibbles(r_width[3:0], r_height[15:12],
                                               r_height[11:8]));
      end
      S_CTRL_D2: begin
        w_load      = 1'b1;
        w_beat_data = DATA_W'(vip_pack_nibbles(r_height[7:4], r_height[3:0],
                                               r_interlaced));
        w_beat_eop  = 1'b1;
      end
      S_VID_HDR: begin
        w_load      = 1'b1;
        w_beat_data = DATA_W'(vip_pack_nibbles(VIP_TYPE_VIDEO, 4'h0, 4'h0));
        w_beat_sop  = 1'b1;
      end
      S_VID_DATA: begin
        w_load      = write;
        w_beat_data = data_in;
        w_beat_eop  = w_pix_eop;
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  // Packet sequencer: latches frame parameters, steps through the control
  // beats and counts video pixels until the frame closes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_width        <= '0;
      r_height       <= '0;
      r_interlaced   <= '0;
      r_frame_size   <= '0;
      r_pixel_cnt    <= '0;
      r_length_error <= 1'b0;
    end else begin
      r_length_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (vip_ctrl_send) begin
            r_width      <= width_in;
            r_height     <= height_in;
            r_interlaced <= interlaced_in;
            r_frame_size <= 32'(width_in) * 32'(height_in);
            r_state      <= S_CTRL_HDR;
          end
        end
        S_CTRL_HDR: if (w_load_ok) r_state <= S_CTRL_D0;
        S_CTRL_D0:  if (w_load_ok) r_state <= S_CTRL_D1;
        S_CTRL_D1:  if (w_load_ok) r_state <= S_CTRL_D2;
        S_CTRL_D2:  if (w_load_ok) r_state <= S_VID_HDR;
        S_VID_HDR: begin
          r_pixel_cnt <= '0;
          if (w_load_ok) r_state <= S_VID_DATA;
        end
        S_VID_DATA: begin
          if (w_pix_load) begin
            r_pixel_cnt <= r_pixel_cnt + 32'd1;
            if (w_pix_eop) begin
              r_state        <= S_IDLE;
              r_length_error <= end_of_video ^ w_cnt_hit;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  vip_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk                (clk),
    .rst                (rst),
    .load               (w_load),
    .load_data          (w_beat_data),
    .load_sop           (w_beat_sop),
    .load_eop           (w_beat_eop),
    .load_ok            (w_load_ok),
    .dout_ready         (dout_ready),
    .dout_data          (dout_data),
    .dout_valid         (dout_valid),
    .dout_startofpacket (dout_startofpacket),
    .dout_endofpacket   (dout_endofpacket)
  );

endmodule
`default_nettype wire
